sat_phase_ctrl: RTL
===================

Name: sat_phase_ctrl

Overview:
- Phase sequencer for one Sat Engine bin. Drives the shared per-variable state array (var-state cells plus their imply/analyze networks) through load, decide, imply, conflict-analyze and backtrack.
- Owns the current decision level and the backtrack level.
- Reports SAT, UNSAT, or "backtrack leaves bin" to the bin manager.

Parameters:
- WIDTH_LVL, 16, decision-level width; matches the var-state cells.
- MAX_IMPLY_CYC, 64, watchdog limit on consecutive IMPLY cycles.
- WIDTH_WD, 7, watchdog counter width; must hold MAX_IMPLY_CYC.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- start_i  in  1  one-cycle pulse; begin a bin run (ignored unless IDLE)
- base_lvl_i  in  WIDTH_LVL  lowest level owned by this bin; sampled on start_i
- done_o  out  1  one-cycle pulse; run finished
- result_o  out  2  00 none, 01 SAT, 10 UNSAT, 11 BKT_OUT; valid with done_o, held until next start_i
- wr_states_o  out  1  load strobe to all var-state cells
- load_ack_i  in  1  load source finished
- dec_req_o  out  1  request a decision candidate
- dec_found_i  in  1  candidate exists (valid while dec_req_o high)
- dec_none_i  in  1  all variables assigned
- valid_from_decision_o  out  1  one-cycle decide strobe
- cur_lvl_o  out  WIDTH_LVL  current decision level
- apply_imply_o  out  1  imply enable
- find_imply_any_i  in  1  OR of cell find_imply
- find_conflict_any_i  in  1  OR of cell find_conflict
- apply_analyze_o  out  1  analyze enable
- analyze_done_i  in  1  learnt clause complete
- max_lvl_i  in  WIDTH_LVL  max over learnt-literal levels
- apply_bkt_o  out  1  one-cycle backtrack strobe
- bkt_lvl_o  out  WIDTH_LVL  backtrack target level

Behaviour:
- Reset (rst=0 at a clock edge): state IDLE.
  - All strobes and enables 0; cur_lvl_o=0, bkt_lvl_o=0, result_o=00, done_o=0.
  - Reset mid-run aborts the run; no done_o is issued.
- States: IDLE, LOAD, DECIDE, IMPLY, ANALYZE, BKT, FINISH.
- IDLE:
  - On start_i: latch base_lvl_i, set cur_lvl=base_lvl_i, clear result, go to LOAD.
- LOAD:
  - wr_states_o=1 every cycle in this state.
  - On load_ack_i: go to IMPLY. Loaded assignments may already imply or conflict.
- DECIDE:
  - dec_req_o=1.
  - dec_none_i has priority: result=SAT, go to FINISH.
  - Else on dec_found_i: valid_from_decision_o=1 for exactly one cycle, cur_lvl+=1 in the same edge, go to IMPLY.
  - The decide strobe carries the incremented level, i.e. the cur_lvl_o value of the next cycle. Implementation presents cur_lvl+1 combinationally during the strobe.
  - cur_lvl at all-ones saturates: result=UNSAT, go to FINISH.
- IMPLY:
  - apply_imply_o=1; watchdog counts cycles.
  - find_conflict_any_i has priority over find_imply_any_i.
  - On conflict: go to ANALYZE.
  - On no conflict and no imply (fixed point): go to DECIDE.
  - Watchdog reaching MAX_IMPLY_CYC is treated as a fixed point.
  - Watchdog clears on every entry to IMPLY.
- ANALYZE:
  - If cur_lvl==base_lvl at entry: result = (base_lvl==0) ? UNSAT : BKT_OUT, go to FINISH; apply_analyze_o is never raised.
  - Else apply_analyze_o=1 until analyze_done_i; on that cycle latch bkt_lvl=max_lvl_i and go to BKT.
- BKT:
  - If bkt_lvl < base_lvl: result=BKT_OUT, go to FINISH, no strobe.
  - Else apply_bkt_o=1 for one cycle, cur_lvl=bkt_lvl, go to IMPLY. The flipped literal propagates from there.
- FINISH: done_o=1 for one cycle, go to IDLE.
- start_i in any non-IDLE state is ignored.
- Inputs are sampled only in their owning state: load_ack_i in LOAD, dec_* in DECIDE, find_*_any_i in IMPLY, analyze_done_i/max_lvl_i in ANALYZE.
- Level arithmetic is unsigned, WIDTH_LVL bits, no wrap.

Optional Feature:
- Macro: SAT_PHASE_CTRL_STATS_EN.
- When defined:
  - Adds outputs stat_dec_o[31:0], stat_confl_o[31:0], stat_wd_o[15:0].
  - stat_dec_o counts decide strobes; stat_confl_o counts ANALYZE entries; stat_wd_o counts watchdog expiries.
  - All three clear on start_i and on reset, and saturate at all-ones.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package sat_ctrl_pkg:
  - state enum (3-bit encoding).
  - result codes RES_NONE/SAT/UNSAT/BKT_OUT.
  - WIDTH_LVL default.
- One natural sub-module: sat_lvl_tracker, holding cur_lvl/bkt_lvl registers, saturating increment and the base_lvl compares.

Test Plan:
- base=0, start; load_ack after 3 cycles; find_imply 2 cycles then quiet; dec_none → SAT. Expected: done_o with result 01; wr_states_o high for exactly 3 cycles.
- base=0; decide twice (cur_lvl 1 then 2); conflict in IMPLY; analyze_done with max_lvl=1 → one apply_bkt_o with bkt_lvl_o=1; cur_lvl_o=1; back in IMPLY.
- base=0; conflict immediately after load (cur_lvl=0) → UNSAT; apply_analyze_o never asserted.
- base=5; decide (cur_lvl 6); conflict; max_lvl=3 → BKT_OUT; no apply_bkt_o.
- find_imply_any_i held high → exit IMPLY after exactly 64 cycles to DECIDE.
- Reset asserted mid-ANALYZE → all outputs 0 next cycle; start_i is then accepted.

Source files
------------

// File: rtl/sat_ctrl_pkg.sv
// Shared types for the Sat Engine bin phase controller: phase encoding,
// result codes and the default decision-level width.
package sat_ctrl_pkg;

    localparam int WIDTH_LVL_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_DECIDE  = 3'd2,
        ST_IMPLY   = 3'd3,
        ST_ANALYZE = 3'd4,
        ST_BKT     = 3'd5,
        ST_FINISH  = 3'd6
    } phase_t;

    typedef enum logic [1:0] {
        RES_NONE    = 2'b00,
        RES_SAT     = 2'b01,
        RES_UNSAT   = 2'b10,
        RES_BKT_OUT = 2'b11
    } result_t;

endpackage

// File: rtl/sat_lvl_tracker.sv
// Decision-level bookkeeping for one bin: base, current and backtrack levels,
// the saturating decide increment and the compares against the bin base.
module sat_lvl_tracker
    import sat_ctrl_pkg::*;
#(
    parameter int WIDTH_LVL = WIDTH_LVL_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_load,
    input  logic [WIDTH_LVL-1:0] base_lvl,
    input  logic                 dec_inc,
    input  logic                 bkt_latch,
    input  logic [WIDTH_LVL-1:0] max_lvl,
    input  logic                 bkt_apply,
    output logic [WIDTH_LVL-1:0] cur_lvl,
    output logic [WIDTH_LVL-1:0] bkt_lvl,
    output logic                 cur_at_base,
    output logic                 cur_sat,
    output logic                 base_zero,
    output logic                 max_below_base,
    output logic                 bkt_below_base
);

    logic [WIDTH_LVL-1:0] cur_reg;
    logic [WIDTH_LVL-1:0] bkt_reg;
    logic [WIDTH_LVL-1:0] base_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_reg  <= '0;
            bkt_reg  <= '0;
            base_reg <= '0;
        end else begin
            if (start_load) begin
                base_reg <= base_lvl;
                cur_reg  <= base_lvl;
            end
            if (dec_inc && !cur_sat)
                cur_reg <= cur_reg + WIDTH_LVL'(1);
            if (bkt_latch)
                bkt_reg <= max_lvl;
            if (bkt_apply)
                cur_reg <= bkt_reg;
        end
    end

    // The decide strobe already carries the level that becomes current on the next edge.
    assign cur_lvl        = (dec_inc && !cur_sat) ? cur_reg + WIDTH_LVL'(1) : cur_reg;
    assign bkt_lvl        = bkt_reg;
    assign cur_at_base    = (cur_reg == base_reg);
    assign cur_sat        = &cur_reg;
    assign base_zero      = (base_reg == '0);
    assign max_below_base = (max_lvl < base_reg);
    assign bkt_below_base = (bkt_reg < base_reg);

endmodule

// File: rtl/sat_phase_ctrl.sv
// Phase sequencer for one Sat Engine bin: load, decide, imply, analyze, backtrack.
// Optional statistics counters are enabled with SAT_PHASE_CTRL_STATS_EN.
module sat_phase_ctrl
    import sat_ctrl_pkg::*;
#(
    parameter int WIDTH_LVL     = WIDTH_LVL_DEF,
    parameter int MAX_IMPLY_CYC = 64,
    parameter int WIDTH_WD      = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [WIDTH_LVL-1:0] base_lvl_i,
    output logic                 done_o,
    output logic [1:0]           result_o,
    output logic                 wr_states_o,
    input  logic                 load_ack_i,
    output logic                 dec_req_o,
    input  logic                 dec_found_i,
    input  logic                 dec_none_i,
    output logic                 valid_from_decision_o,
    output logic [WIDTH_LVL-1:0] cur_lvl_o,
    output logic                 apply_imply_o,
    input  logic                 find_imply_any_i,
    input  logic                 find_conflict_any_i,
    output logic                 apply_analyze_o,
    input  logic                 analyze_done_i,
    input  logic [WIDTH_LVL-1:0] max_lvl_i,
    output logic                 apply_bkt_o,
    output logic [WIDTH_LVL-1:0] bkt_lvl_o
`ifdef SAT_PHASE_CTRL_STATS_EN
    ,
    output logic [31:0]          stat_dec_o,
    output logic [31:0]          stat_confl_o,
    output logic [15:0]          stat_wd_o
`endif
);

    phase_t              state;
    result_t             result_q;
    logic [WIDTH_WD-1:0] wd_cnt;

    logic start_run;
    logic dec_strobe;
    logic bkt_latch;
    logic bkt_apply;
    logic wd_last;
    logic wd_expire;
    logic confl_entry;

    logic cur_at_base;
    logic cur_sat;
    logic base_zero;
    logic max_below_base;
    logic bkt_below_base;

    assign start_run   = (state == ST_IDLE) && start_i;
    assign dec_strobe  = (state == ST_DECIDE) && !dec_none_i && dec_found_i && !cur_sat;
    assign bkt_latch   = (state == ST_ANALYZE) && !cur_at_base && analyze_done_i;
    assign bkt_apply   = (state == ST_BKT) && !bkt_below_base;
    assign wd_last     = (wd_cnt == WIDTH_WD'(MAX_IMPLY_CYC - 1));
    assign wd_expire   = (state == ST_IMPLY) && !find_conflict_any_i && find_imply_any_i && wd_last;
    assign confl_entry = (state == ST_IMPLY) && find_conflict_any_i;

    assign valid_from_decision_o = dec_strobe;
    assign result_o              = result_q;

    sat_lvl_tracker #(
        .WIDTH_LVL (WIDTH_LVL)
    ) u_lvl (
        .clk            (clk),
        .rst            (rst),
        .start_load     (start_run),
        .base_lvl       (base_lvl_i),
        .dec_inc        (dec_strobe),
        .bkt_latch      (bkt_latch),
        .max_lvl        (max_lvl_i),
        .bkt_apply      (bkt_apply),
        .cur_lvl        (cur_lvl_o),
        .bkt_lvl        (bkt_lvl_o),
        .cur_at_base    (cur_at_base),
        .cur_sat        (cur_sat),
        .base_zero      (base_zero),
        .max_below_base (max_below_base),
        .bkt_below_base (bkt_below_base)
    );

    // Enables are registered on the transition into their owning state, so they
    // line up exactly with the state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= ST_IDLE;
            result_q        <= RES_NONE;
            done_o          <= 1'b0;
            wr_states_o     <= 1'b0;
            dec_req_o       <= 1'b0;
            apply_imply_o   <= 1'b0;
            apply_analyze_o <= 1'b0;
            apply_bkt_o     <= 1'b0;
            wd_cnt          <= '0;
        end else begin
            done_o      <= 1'b0;
            apply_bkt_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        result_q    <= RES_NONE;
                        wr_states_o <= 1'b1;
                        state       <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (load_ack_i) begin
                        wr_states_o   <= 1'b0;
                        apply_imply_o <= 1'b1;
                        wd_cnt        <= '0;
                        state         <= ST_IMPLY;
                    end
                end
                ST_DECIDE: begin
                    if (dec_none_i) begin
                        dec_req_o <= 1'b0;
                        result_q  <= RES_SAT;
                        done_o    <= 1'b1;
                        state     <= ST_FINISH;
                    end else if (dec_found_i) begin
                        dec_req_o <= 1'b0;
                        if (cur_sat) begin
                            result_q <= RES_UNSAT;
                            done_o   <= 1'b1;
                            state    <= ST_FINISH;
                        end else begin
                            apply_imply_o <= 1'b1;
                            wd_cnt        <= '0;
                            state         <= ST_IMPLY;
                        end
                    end
                end
                ST_IMPLY: begin
                    if (find_conflict_any_i) begin
                        apply_imply_o   <= 1'b0;
                        apply_analyze_o <= !cur_at_base;
                        state           <= ST_ANALYZE;
                    end else if (!find_imply_any_i || wd_last) begin
                        apply_imply_o <= 1'b0;
                        dec_req_o     <= 1'b1;
                        state         <= ST_DECIDE;
                    end else begin
                        wd_cnt <= wd_cnt + WIDTH_WD'(1);
                    end
                end
                ST_ANALYZE: begin
                    // A conflict at the bin's own base level cannot be resolved inside this bin.
                    if (cur_at_base) begin
                        result_q <= base_zero ? RES_UNSAT : RES_BKT_OUT;
                        done_o   <= 1'b1;
                        state    <= ST_FINISH;
                    end else if (analyze_done_i) begin
                        apply_analyze_o <= 1'b0;
                        apply_bkt_o     <= !max_below_base;
                        state           <= ST_BKT;
                    end
                end
                ST_BKT: begin
                    if (bkt_below_base) begin
                        result_q <= RES_BKT_OUT;
                        done_o   <= 1'b1;
                        state    <= ST_FINISH;
                    end else begin
                        apply_imply_o <= 1'b1;
                        wd_cnt        <= '0;
                        state         <= ST_IMPLY;
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SAT_PHASE_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst || start_run) begin
            stat_dec_o   <= '0;
            stat_confl_o <= '0;
            stat_wd_o    <= '0;
        end else begin
            if (dec_strobe && !(&stat_dec_o))
                stat_dec_o <= stat_dec_o + 32'd1;
            if (confl_entry && !(&stat_confl_o))
                stat_confl_o <= stat_confl_o + 32'd1;
            if (wd_expire && !(&stat_wd_o))
                stat_wd_o <= stat_wd_o + 16'd1;
        end
    end
`else
    logic unused_stats;
    assign unused_stats = confl_entry ^ wd_expire;
`endif

endmodule
